// File: rtl/wb_sdrc_arbiter.sv
// wb_sdrc_arbiter: round-robin two-master Wishbone arbiter with ack timeout in front of the SDRAM controller slave port
module wb_sdrc_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int TW = 8,
  parameter int CW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          sdr_init_done_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o,
  output logic [CW-1:0] tmo_cnt_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  logic [1:0]    state, state_nx;
  logic          last, last_nx;
  logic [TW-1:0] timer;
  logic          g0, g1, x_stb, err_now;
  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: if (sdr_init_done_i)
        state_nx = (m0_cyc_i & m1_cyc_i) ? (last ? GNT0 : GNT1) :
                   m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
      GNT0: if (!m0_cyc_i) begin
        last_nx  = 1'b0;
        state_nx = (m1_cyc_i & sdr_init_done_i) ? GNT1 : IDLE;
      end
      GNT1: if (!m1_cyc_i) begin
        last_nx  = 1'b1;
        state_nx = (m0_cyc_i & sdr_init_done_i) ? GNT0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign g0      = state == GNT0;
  assign g1      = state == GNT1;
  assign gnt_o   = {g1, g0};
  assign x_stb   = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign err_now = s_cyc_o & x_stb & (timer == TW'(ACK_TIMEOUT - 1)) & ~s_ack_i;
  assign s_stb_o = x_stb & ~err_now;
  assign s_we_o  = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign s_adr_o = g1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = g1 ? m1_dat_i : m0_dat_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & m0_cyc_i & s_ack_i;
  assign m1_ack_o = g1 & m1_cyc_i & s_ack_i;
  assign m0_err_o = g0 & err_now;
  assign m1_err_o = g1 & err_now;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      last      <= 1'b1;
      timer     <= '0;
      tmo_cnt_o <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      timer     <= (s_cyc_o & s_stb_o & ~s_ack_i & (state_nx == state)) ? timer + 1'b1 : '0;
      if (err_now & ~&tmo_cnt_o)
        tmo_cnt_o <= tmo_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// tb_wb_sdrc_arbiter: scoreboard bench for the two-master SDRAM Wishbone arbiter
module tb_wb_sdrc_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic        init_done = 0;
  logic [1:0]  cyc = 0, stb = 0, we = 0, ack, err;
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [31:0] rdat [2];
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]  gnt_o;
  logic [7:0]  tmo_cnt_o;
  logic        ack_en = 1;
  int          ack_dly = 1;
  int          wcnt;
  int          errors = 0, checks = 0;
  typedef struct {logic w; logic [31:0] a; logic [31:0] d;} exp_t;
  exp_t sb [$];
  always #5 clk = ~clk;
  wb_sdrc_arbiter #(.ACK_TIMEOUT(8), .TW(4), .CW(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sdr_init_done_i(init_done),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat_o(rdat[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat_o(rdat[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .tmo_cnt_o(tmo_cnt_o)
  );
  assign s_dat_i = ~s_adr_o;
  assign s_ack_i = ack_en & s_cyc_o & (wcnt == ack_dly);
  always_ff @(posedge clk) wcnt <= (rst | ~s_cyc_o | s_ack_i) ? 0 : wcnt + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n = 0;
    stb[m] = 1; we[m] = w; adr[m] = a; dat[m] = d; sel[m] = 4'hF;
    sb.push_back('{w: w, a: a, d: w ? d : ~a});
    @(negedge clk);
    while (!ack[m] && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (!ack[m]) begin
      errors++;
      $display("FAIL xfer_ack m%0d adr=%h: no ack within 40 cycles", m, a);
    end else if (s_adr_o !== e.a || s_we_o !== e.w || (e.w ? s_dat_o : rdat[m]) !== e.d) begin
      errors++;
      $display("FAIL xfer_data m%0d: adr=%h we=%b data=%h, required adr=%h we=%b data=%h",
               m, s_adr_o, s_we_o, e.w ? s_dat_o : rdat[m], e.a, e.w, e.d);
    end
    tick();
    stb[m] = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, ack, err, tmo_cnt_o} !== 15'd0) begin
      errors++;
      $display("FAIL reset: gnt=%b cyc=%b stb=%b ack=%b err=%b tmo=%0d, required all 0",
               gnt_o, s_cyc_o, s_stb_o, ack, err, tmo_cnt_o);
    end
    tick();
    rst = 0;
  endtask
  task automatic test_init_gate();
    init_done = 0; cyc[0] = 1; stb[0] = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL init_gate c%0d: gnt=%b s_cyc=%b, required 00/0", i, gnt_o, s_cyc_o);
      end
      tick();
    end
    init_done = 1;
    tick();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL init_grant: gnt=%b s_cyc=%b, required 01/1", gnt_o, s_cyc_o);
    end
    cyc[0] = 0; stb[0] = 0;
    tick();
    tick();
  endtask
  task automatic test_tie_and_handoff();
    test_reset();
    cyc = 2'b11;
    tick();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL tie_first: gnt=%b, required 01", gnt_o);
    end
    tick();
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
    cyc[0] = 0;
    tick();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL handoff: gnt=%b, required 10", gnt_o);
    end
    tick();
    xfer(1, 1'b0, 32'h180, 32'h0);
    cyc[1] = 0;
    tick();
    tick();
  endtask
  task automatic test_back_to_back();
    test_reset();
    cyc = 2'b11;
    tick();
    for (int r = 0; r < 4; r++) begin
      int e = r % 2;
      @(negedge clk);
      checks++;
      if (gnt_o !== (e ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alternate r%0d: gnt=%b, required %b", r, gnt_o, e ? 2'b10 : 2'b01);
      end
      tick();
      xfer(e, 1'b1, 32'h200 + 32'(r * 4), 32'(r + 7));
      cyc[e] = 0;
      tick();
      cyc[e] = 1;
    end
    cyc = 2'b00;
    tick();
    tick();
  endtask
  task automatic test_timeout();
    ack_en = 0; cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h400;
    tick();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (k < 8 && (err[0] !== 1'b0 || s_stb_o !== 1'b1 || gnt_o !== 2'b01)) begin
        errors++;
        $display("FAIL tmo_wait k%0d: err=%b stb=%b gnt=%b, required 0/1/01", k, err[0], s_stb_o, gnt_o);
      end
      if (k == 8 && (err !== 2'b01 || s_stb_o !== 1'b0)) begin
        errors++;
        $display("FAIL tmo_err: err=%b stb=%b, required 01/0", err, s_stb_o);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (tmo_cnt_o !== 8'd1 || err[0] !== 1'b0 || s_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_after: tmo=%0d err=%b stb=%b, required 1/0/1", tmo_cnt_o, err[0], s_stb_o);
    end
    cyc[0] = 0; stb[0] = 0;
    tick();
    tick();
  endtask
  task automatic test_ack_at_limit();
    ack_en = 1; ack_dly = 7; cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h500;
    tick();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) begin
        checks++;
        if (ack[0] !== 1'b1 || err[0] !== 1'b0 || rdat[0] !== ~32'h500) begin
          errors++;
          $display("FAIL ack_limit: ack=%b err=%b dat=%h, required 1/0/%h", ack[0], err[0], rdat[0], ~32'h500);
        end
      end
      tick();
    end
    stb[0] = 0;
    @(negedge clk);
    checks++;
    if (tmo_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL ack_limit_cnt: tmo=%0d, required 1", tmo_cnt_o);
    end
    cyc[0] = 0;
    ack_dly = 1;
    tick();
    tick();
  endtask
  task automatic test_reset_mid_read();
    ack_en = 0; cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h300; sel[1] = 4'hF;
    tick();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: gnt=%b s_cyc=%b, required 10/1", gnt_o, s_cyc_o);
    end
    tick();
    rst = 1; ack_en = 1;
    tick();
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, tmo_cnt_o, ack, err} !== 21'd0) begin
      errors++;
      $display("FAIL rst_mid: gnt=%b cyc=%b stb=%b we=%b sel=%h tmo=%0d ack=%b err=%b, required all 0",
               gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, tmo_cnt_o, ack, err);
    end
    rst = 0; cyc[1] = 0; stb[1] = 0;
    tick();
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      sel[i] = 0; adr[i] = 0; dat[i] = 0;
    end
    test_reset();
    test_init_gate();
    test_tie_and_handoff();
    test_back_to_back();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_sdrc_arbiter.md
Name: wb_sdrc_arbiter

Overview:
- Two-master Wishbone arbiter placed in front of the SDRAM controller's single Wishbone slave port.
- Shares that port between two requesters using round-robin, with grant lock held for the whole bus cycle.
- Returns a bus error to the granted master if the controller fails to ack within a bounded time, and counts those timeouts.
- Issues no grant until SDRAM initialisation completes.

Parameters:
AW, 32, address width
DW, 32, data width
SW, DW/8, byte-select width
ACK_TIMEOUT, 255, max cycles of unacked strobe before err (>=2)
TW, 8, timeout counter width (must hold ACK_TIMEOUT)
CW, 8, saturating timeout-event counter width

Ports:
wb_clk_i  in  1  system clock, all logic rising-edge
wb_rst_i  in  1  synchronous active-high reset
sdr_init_done_i  in  1  SDRAM init complete; no new grant while low
m0_cyc_i / m0_stb_i / m0_we_i  in  1 each  master 0 Wishbone controls
m0_sel_i  in  SW  master 0 byte selects
m0_adr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_dat_o  out  DW  read data to master 0
m0_ack_o / m0_err_o  out  1 each  master 0 ack / error
m1_*  (same set, same widths)  master 1
s_cyc_o / s_stb_o / s_we_o  out  1 each  to SDRAM controller
s_sel_o  out  SW
s_adr_o  out  AW
s_dat_o  out  DW
s_dat_i  in  DW  read data from controller
s_ack_i  in  1  ack from controller
gnt_o  out  2  one-hot grant {m1,m0}; 00 = idle
tmo_cnt_o  out  CW  saturating count of timeout events

Behaviour:
- Clock and reset: one clock (wb_clk_i); reset wb_rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE, gnt_o=00, last=1 (m0 wins first tie).
  - Timer=0, tmo_cnt_o=0.
  - All s_* controls=0; all m*_ack_o/m*_err_o=0.
- FSM states: IDLE, GNT0, GNT1. State is registered; the grant takes effect the cycle after the decision.
- From IDLE (only when sdr_init_done_i=1):
  - Only m0_cyc_i → GNT0; only m1_cyc_i → GNT1.
  - Both → the master not equal to last.
  - Neither, or init_done=0 → stay IDLE.
- From GNTx:
  - Hold while mx_cyc_i=1.
  - When mx_cyc_i=0: last←x; next = GNT(other) if other cyc=1 and init_done=1, else IDLE.
  - Back-to-back re-grant of the same master passes through IDLE, so the other master gets priority at the tie.
- Request latency: cyc asserted in IDLE at cycle t → gnt_o and s_cyc_o at t+1.
- Slave mux (combinational from state):
  - In GNTx, s_cyc_o=mx_cyc_i and s_stb_o=mx_stb_i & ~err_now; we/sel/adr/dat follow master x.
  - In IDLE, all s_* controls are 0; adr/dat are don't-care but driven from m0.
- Return path:
  - m0_dat_o=m1_dat_o=s_dat_i.
  - mx_ack_o=s_ack_i only when in GNTx; the non-granted master always sees ack=0, err=0.
- Ack timeout:
  - Timer increments each cycle with s_cyc_o & s_stb_o & ~s_ack_i; clears on s_ack_i, on a state change, or when not strobing.
  - err_now = (timer==ACK_TIMEOUT-1) & ~s_ack_i.
  - err_now asserts mx_err_o for exactly one cycle and masks s_stb_o that cycle; timer clears next cycle.
  - tmo_cnt_o increments per event and saturates at 2^CW-1.
- Simultaneous ack and timeout in the same cycle: ack wins; no err, no count.
- Granted master dropping cyc mid-wait: the grant is released and the timer is cleared; a late s_ack_i is discarded (not routed).
- sdr_init_done_i falling while in GNTx: the current cycle completes; no new grant is issued.
- wb_rst_i mid-transfer: next edge forces reset values; any outstanding slave ack is dropped.

Test Plan:
1. init_done=0, m0_cyc=1 for 10 cycles → gnt_o=00, s_cyc_o=0; raise init_done → gnt_o=01 next cycle.
2. m0 and m1 assert cyc on the same cycle after reset → m0 granted; m0 completes 4 acked writes (adr 0x100..0x10C) and drops cyc → gnt_o=10 one cycle later.
3. m1 holds cyc while m0 repeatedly re-requests → grants alternate 01,10,01,10; no master is granted twice while the other waits.
4. ACK_TIMEOUT=8, slave never acks → m0_err_o pulses on the 8th strobed cycle, s_stb_o=0 that cycle, tmo_cnt_o=1, m1_err_o=0.
5. Slave acks exactly on cycle 8 → m0_ack_o=1, err=0, tmo_cnt_o unchanged.
6. wb_rst_i asserted during a GNT1 read → next cycle gnt_o=00, all s_* controls=0, tmo_cnt_o=0.
